// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - digit load/decode controls and scanned display outputs
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic                  hex_mode;
  logic [6:0]            out_7seg;
  logic [DIGITS-1:0]     digit_en;

  modport master (
    output load,
    output data_in,
    output hex_mode,
    input  out_7seg,
    input  digit_en
  );

  modport slave (
    input  load,
    input  data_in,
    input  hex_mode,
    output out_7seg,
    output digit_en
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit seven-segment scan driver
// Define SEG7_LZB_EN to blank leading zeros (digit 0 always shown).
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  seg7_scan_driver_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   en_q, en_d;

  logic                tick;
  logic [IDX_W-1:0]    idx_nxt;
  logic [3:0]          cur_digit;
  logic                cur_blank;
  logic [DIGITS-1:0]   lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] code, input logic hex);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'b100_0000;
      4'h1:    seg = 7'b111_1001;
      4'h2:    seg = 7'b010_0100;
      4'h3:    seg = 7'b011_0000;
      4'h4:    seg = 7'b001_1001;
      4'h5:    seg = 7'b001_0010;
      4'h6:    seg = 7'b000_0010;
      4'h7:    seg = 7'b111_1000;
      4'h8:    seg = 7'b000_0000;
      4'h9:    seg = 7'b001_0000;
      4'hA:    seg = hex ? 7'b000_1000 : 7'b111_1111;
      4'hB:    seg = hex ? 7'b000_0011 : 7'b111_1111;
      4'hC:    seg = hex ? 7'b100_0110 : 7'b111_1111;
      4'hD:    seg = hex ? 7'b010_0001 : 7'b111_1111;
      4'hE:    seg = hex ? 7'b000_0110 : 7'b111_1111;
      default: seg = hex ? 7'b000_1110 : 7'b111_1111;
    endcase
    return seg;
  endfunction

`ifdef SEG7_LZB_EN
  // Walk from the most significant digit down; blank until the first non-zero digit.
  always_comb begin
    logic seen_nz;
    seen_nz  = 1'b0;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen_nz     = seen_nz | (shadow_q[4*i +: 4] != 4'h0);
      lz_blank[i] = (i != 0) && !seen_nz;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    idx_nxt   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    shadow_d  = bus.load ? bus.data_in : shadow_q;
    idx_d     = idx_q;
    seg_d     = seg_q;
    en_d      = en_q;
    cur_digit = 4'h0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        cur_digit = shadow_q[4*i +: 4];
        cur_blank = lz_blank[i];
      end
    end
    // Decode reads the pre-load shadow, so a load on the tick edge shows next slot.
    if (tick) begin
      idx_d = idx_nxt;
      seg_d = cur_blank ? 7'b111_1111 : decode(cur_digit, bus.hex_mode);
      en_d  = ~(DIGITS'(1) << idx_nxt);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      div_q    <= '0;
      idx_q    <= IDX_LAST;
      seg_q    <= 7'b111_1111;
      en_q     <= '1;
    end else begin
      shadow_q <= shadow_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      en_q     <= en_d;
    end
  end

  assign bus.out_7seg = seg_q;
  assign bus.digit_en = en_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized bench for seg7_scan_driver against a slot-arithmetic model
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus();

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [6:0] model_seg(input logic [15:0] sh, input int d, input logic hex);
    logic [3:0] code;
    code = 4'((sh >> (4*d)) & 16'hF);
`ifdef SEG7_LZB_EN
    if (d >= 1 && (sh >> (4*d)) == 16'h0) return 7'h7F;
`endif
    if (code >= 4'd10 && !hex) return 7'h7F;
    return seg_tab[code];
  endfunction

  // Model: edges counted since reset release; edge n is a tick when n mod SCAN_DIV == SCAN_DIV-1.
  logic [15:0] m_shadow;
  int          m_cycles;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_en;

  always @(posedge clk or negedge rst_n) begin
    int slot;
    int d;
    if (!rst_n) begin
      m_shadow <= 16'h0;
      m_cycles <= 0;
      exp_seg  <= 7'h7F;
      exp_en   <= 4'hF;
    end else begin
      if (m_cycles % SCAN_DIV == SCAN_DIV - 1) begin
        slot = (m_cycles + 1) / SCAN_DIV - 1;
        d    = slot % DIGITS;
        exp_seg <= model_seg(m_shadow, d, bus.hex_mode);
        exp_en  <= ~(4'b0001 << d);
      end
      if (bus.load) m_shadow <= bus.data_in;
      m_cycles <= m_cycles + 1;
    end
  end

  task automatic test_reset;
    bus.load = 1'b0; bus.data_in = 16'h0; bus.hex_mode = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.out_7seg !== 7'h7F || bus.digit_en !== 4'hF) begin
      bad++; $display("FAIL reset_hold: got seg=%h en=%b want seg=7f en=1111", bus.out_7seg, bus.digit_en);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus.out_7seg !== 7'h7F || bus.digit_en !== 4'hF) begin
        bad++; $display("FAIL reset_pre_tick c=%0d: got seg=%h en=%b want seg=7f en=1111", c, bus.out_7seg, bus.digit_en);
      end
    end
    @(negedge clk);
    total++;
    if (bus.out_7seg !== 7'h40 || bus.digit_en !== 4'b1110) begin
      bad++; $display("FAIL reset_first_digit: got seg=%h en=%b want seg=40 en=1110", bus.out_7seg, bus.digit_en);
    end
  endtask

  task automatic test_scan_order;
    int run;
    int runs_seen;
    logic [3:0] prev_en;
    bus.data_in = 16'h1234; bus.hex_mode = 1'b0; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    run = 0; runs_seen = 0; prev_en = bus.digit_en;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      total++;
      if (bus.out_7seg !== exp_seg || bus.digit_en !== exp_en) begin
        bad++; $display("FAIL scan_model c=%0d: got seg=%h en=%b want seg=%h en=%b", c, bus.out_7seg, bus.digit_en, exp_seg, exp_en);
      end
      if (c >= SCAN_DIV && bus.digit_en === 4'b1110) begin
        total++;
        if (bus.out_7seg !== 7'h19) begin
          bad++; $display("FAIL scan_digit0: got seg=%h want 19", bus.out_7seg);
        end
      end
      if (c >= SCAN_DIV && bus.digit_en === 4'b0111) begin
        total++;
        if (bus.out_7seg !== 7'h79) begin
          bad++; $display("FAIL scan_digit3: got seg=%h want 79", bus.out_7seg);
        end
      end
      if (bus.digit_en === prev_en) run++;
      else begin
        if (runs_seen > 0) begin
          total++;
          if (run !== SCAN_DIV) begin
            bad++; $display("FAIL scan_slot_len: got %0d cycles want %0d", run, SCAN_DIV);
          end
        end
        runs_seen++; run = 1; prev_en = bus.digit_en;
      end
    end
  endtask

  task automatic test_mode;
    bus.data_in = 16'h00AF; bus.hex_mode = 1'b1; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++;
      if (bus.out_7seg !== exp_seg || bus.digit_en !== exp_en) begin
        bad++; $display("FAIL mode_hex_model c=%0d: got seg=%h en=%b want seg=%h en=%b", c, bus.out_7seg, bus.digit_en, exp_seg, exp_en);
      end
      if (c >= SCAN_DIV && bus.digit_en === 4'b1110) begin
        total++;
        if (bus.out_7seg !== 7'h0E) begin bad++; $display("FAIL mode_hex_F: got seg=%h want 0e", bus.out_7seg); end
      end
      if (c >= SCAN_DIV && bus.digit_en === 4'b1101) begin
        total++;
        if (bus.out_7seg !== 7'h08) begin bad++; $display("FAIL mode_hex_A: got seg=%h want 08", bus.out_7seg); end
      end
    end
    bus.hex_mode = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++;
      if (bus.out_7seg !== exp_seg || bus.digit_en !== exp_en) begin
        bad++; $display("FAIL mode_bcd_model c=%0d: got seg=%h en=%b want seg=%h en=%b", c, bus.out_7seg, bus.digit_en, exp_seg, exp_en);
      end
      if (c >= SCAN_DIV && (bus.digit_en === 4'b1110 || bus.digit_en === 4'b1101)) begin
        total++;
        if (bus.out_7seg !== 7'h7F) begin bad++; $display("FAIL mode_bcd_blank: got seg=%h want 7f", bus.out_7seg); end
      end
    end
  endtask

  task automatic test_collision;
    logic [6:0] want_old;
    int d;
    bool_found: begin end
    bus.data_in = 16'h1234; bus.hex_mode = 1'b0; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (SCAN_DIV) @(negedge clk);
    for (int w = 0; w < 2*SCAN_DIV && (m_cycles % SCAN_DIV != SCAN_DIV - 1); w++) @(negedge clk);
    total++;
    if (m_cycles % SCAN_DIV != SCAN_DIV - 1) begin
      bad++; $display("FAIL collision_align: got phase %0d want %0d", m_cycles % SCAN_DIV, SCAN_DIV - 1);
    end
    d = ((m_cycles + 1) / SCAN_DIV - 1) % DIGITS;
    want_old = model_seg(16'h1234, d, 1'b0);
    bus.data_in = 16'h5555; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    total++;
    if (bus.out_7seg !== want_old || bus.digit_en !== exp_en) begin
      bad++; $display("FAIL collision_old: got seg=%h en=%b want seg=%h en=%b", bus.out_7seg, bus.digit_en, want_old, exp_en);
    end
    repeat (SCAN_DIV) @(negedge clk);
    total++;
    if (bus.out_7seg !== 7'h12 || bus.digit_en !== exp_en) begin
      bad++; $display("FAIL collision_new: got seg=%h en=%b want seg=12 en=%b", bus.out_7seg, bus.digit_en, exp_en);
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      total++;
      if (bus.out_7seg !== exp_seg || bus.digit_en !== exp_en) begin
        bad++; $display("FAIL random c=%0d: got seg=%h en=%b want seg=%h en=%b", c, bus.out_7seg, bus.digit_en, exp_seg, exp_en);
      end
      bus.load    = ($urandom_range(0, 5) == 0);
      bus.data_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 11) == 0) bus.hex_mode = ~bus.hex_mode;
    end
    bus.load = 1'b0;
  endtask

  task automatic test_midscan_reset;
    bus.data_in = 16'h1238; bus.hex_mode = 1'b0; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int w = 0; w < 4*DIGITS*SCAN_DIV && exp_en !== 4'b1011; w++) @(negedge clk);
    total++;
    if (bus.digit_en !== 4'b1011) begin
      bad++; $display("FAIL midreset_reach_digit2: got en=%b want 1011", bus.digit_en);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_7seg !== 7'h7F || bus.digit_en !== 4'hF) begin
      bad++; $display("FAIL midreset_async: got seg=%h en=%b want seg=7f en=1111", bus.out_7seg, bus.digit_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < SCAN_DIV - 1; c++) begin
      @(negedge clk);
      total++;
      if (bus.out_7seg !== 7'h7F || bus.digit_en !== 4'hF) begin
        bad++; $display("FAIL midreset_hold c=%0d: got seg=%h en=%b want seg=7f en=1111", c, bus.out_7seg, bus.digit_en);
      end
    end
    @(negedge clk);
    total++;
    if (bus.out_7seg !== 7'h40 || bus.digit_en !== 4'b1110) begin
      bad++; $display("FAIL midreset_restart: got seg=%h en=%b want seg=40 en=1110", bus.out_7seg, bus.digit_en);
    end
    for (int c = 0; c < DIGITS*SCAN_DIV; c++) begin
      @(negedge clk);
      total++;
      if (bus.out_7seg !== exp_seg || bus.digit_en !== exp_en) begin
        bad++; $display("FAIL midreset_model c=%0d: got seg=%h en=%b want seg=%h en=%b", c, bus.out_7seg, bus.digit_en, exp_seg, exp_en);
      end
    end
  endtask

  task automatic test_lzb;
    logic [6:0] want;
    bus.data_in = 16'h0040; bus.hex_mode = 1'b0; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int c = 0; c < 3*DIGITS*SCAN_DIV; c++) begin
      @(negedge clk);
      if (c == DIGITS*SCAN_DIV) begin
        bus.data_in = 16'h0000; bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      total++;
      if (bus.out_7seg !== exp_seg || bus.digit_en !== exp_en) begin
        bad++; $display("FAIL lzb_model c=%0d: got seg=%h en=%b want seg=%h en=%b", c, bus.out_7seg, bus.digit_en, exp_seg, exp_en);
      end
      if (c >= SCAN_DIV && c < DIGITS*SCAN_DIV) begin
        case (bus.digit_en)
          4'b1110: want = 7'h40;
          4'b1101: want = 7'h19;
`ifdef SEG7_LZB_EN
          default: want = 7'h7F;
`else
          default: want = 7'h40;
`endif
        endcase
        total++;
        if (bus.out_7seg !== want) begin
          bad++; $display("FAIL lzb_0040 en=%b: got seg=%h want %h", bus.digit_en, bus.out_7seg, want);
        end
      end
      if (c >= 2*DIGITS*SCAN_DIV) begin
`ifdef SEG7_LZB_EN
        want = (bus.digit_en === 4'b1110) ? 7'h40 : 7'h7F;
`else
        want = 7'h40;
`endif
        total++;
        if (bus.out_7seg !== want) begin
          bad++; $display("FAIL lzb_zero en=%b: got seg=%h want %h", bus.digit_en, bus.out_7seg, want);
        end
      end
    end
    bus.load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_mode();
    test_collision();
    test_random();
    test_midscan_reset();
    test_lzb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
